// File: rtl/fmc_regbank.sv
// fmc_regbank: STM32 FMC/FSMC multiplexed-bus slave with a parametrised
// register bank (NUM_RW control + NUM_CH-NUM_RW status channels).
//
// Ports:
//   CLK, RST (async, active-low)
//   FPGA_NL_NADV, FPGA_CS_NEL, FPGA_WR_NWE, FPGA_RD_NOE : bus strobes (low)
//   FPGA_DB   : 16-bit multiplexed address/data, driven only during reads
//   ctrl_data : control registers, channel k at [16k+15:16k]
//   stat_data : status inputs, channel NUM_RW+j at [16j+15:16j]
//   wr_stb    : one-cycle pulse per control channel written
//   rd_stb    : one-cycle pulse at start of a read of channel k
//   bad_addr  : one-cycle pulse on an access to address >= NUM_CH
//
// Build option: define FMC_SNAPSHOT_EN to read status from a shadow bank
// captured on the address phase of a status address (coherent reads).

`default_nettype none

module fmc_regbank #(
  parameter int          NUM_CH      = 16,
  parameter int          NUM_RW      = 8,
  parameter int          ADDR_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RST_VAL     = 16'h0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FPGA_NL_NADV,
  input  logic                   FPGA_CS_NEL,
  input  logic                   FPGA_WR_NWE,
  input  logic                   FPGA_RD_NOE,
  inout  wire  [15:0]            FPGA_DB,
  output logic [NUM_RW*16-1:0]   ctrl_data,
  input  logic [((NUM_CH > NUM_RW) ? (NUM_CH - NUM_RW) : 1)*16-1:0]
                                 stat_data,
  output logic [NUM_RW-1:0]      wr_stb,
  output logic [NUM_CH-1:0]      rd_stb,
  output logic                   bad_addr
);

  localparam int NUM_ST = NUM_CH - NUM_RW;
  localparam int ST_N   = (NUM_ST > 0) ? NUM_ST : 1;

  localparam logic [31:0] RW_U = 32'(NUM_RW);
  localparam logic [31:0] CH_U = 32'(NUM_CH);

  // Synchronisers: strobes and data share one depth so they stay aligned
  logic [SYNC_STAGES-1:0] nadv_sr;
  logic [SYNC_STAGES-1:0] ne_sr;
  logic [SYNC_STAGES-1:0] nwe_sr;
  logic [SYNC_STAGES-1:0] noe_sr;
  logic [15:0]            db_sr [SYNC_STAGES];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      nadv_sr <= '1;
      ne_sr   <= '1;
      nwe_sr  <= '1;
      noe_sr  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        db_sr[i] <= '0;
      end
    end else begin
      nadv_sr  <= {nadv_sr[SYNC_STAGES-2:0], FPGA_NL_NADV};
      ne_sr    <= {ne_sr[SYNC_STAGES-2:0], FPGA_CS_NEL};
      nwe_sr   <= {nwe_sr[SYNC_STAGES-2:0], FPGA_WR_NWE};
      noe_sr   <= {noe_sr[SYNC_STAGES-2:0], FPGA_RD_NOE};
      db_sr[0] <= FPGA_DB;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        db_sr[i] <= db_sr[i-1];
      end
    end
  end

  logic        nadv_s;
  logic        ne_s;
  logic        nwe_s;
  logic        noe_s;
  logic [15:0] db_s;

  assign nadv_s = nadv_sr[SYNC_STAGES-1];
  assign ne_s   = ne_sr[SYNC_STAGES-1];
  assign nwe_s  = nwe_sr[SYNC_STAGES-1];
  assign noe_s  = noe_sr[SYNC_STAGES-1];
  assign db_s   = db_sr[SYNC_STAGES-1];

  // Edge detection on synchronised strobes
  logic nadv_p_q;
  logic ne_p_q;
  logic nwe_p_q;
  logic noe_p_q;

  logic nadv_rise;
  logic ne_rise;
  logic nwe_rise;
  logic noe_fall;

  assign nadv_rise = nadv_s & ~nadv_p_q;
  assign ne_rise   = ne_s & ~ne_p_q;
  assign nwe_rise  = nwe_s & ~nwe_p_q;
  assign noe_fall  = ~noe_s & noe_p_q;

  // State
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              rd_act_q, rd_act_d;
  logic [15:0]       dout_q, dout_d;
  logic [15:0]       ctrl_q [NUM_RW];
  logic [15:0]       ctrl_d [NUM_RW];
  logic [NUM_RW-1:0] wr_stb_q, wr_stb_d;
  logic [NUM_CH-1:0] rd_stb_q, rd_stb_d;
  logic              bad_q, bad_d;

  logic        latch;
  logic [31:0] addr_w;
  logic [31:0] anew_w;
  logic        addr_rw;
  logic        addr_ok;

  assign latch   = nadv_rise & ~ne_s;
  assign addr_w  = 32'(addr_q);
  assign anew_w  = 32'(db_s[ADDR_W-1:0]);
  assign addr_rw = addr_w < RW_U;
  assign addr_ok = addr_w < CH_U;

  // Read sources per channel
  logic [15:0] rdval [NUM_CH];

`ifdef FMC_SNAPSHOT_EN
  logic [15:0] shad_q [ST_N];
  logic        st_new;

  assign st_new = (anew_w >= RW_U) && (anew_w < CH_U);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < ST_N; k++) begin
        shad_q[k] <= '0;
      end
    end else if (latch && st_new) begin
      for (int k = 0; k < NUM_ST; k++) begin
        shad_q[k] <= stat_data[16*k +: 16];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      rdval[k] = '0;
    end
    for (int k = 0; k < NUM_RW; k++) begin
      rdval[k] = ctrl_q[k];
    end
    for (int k = NUM_RW; k < NUM_CH; k++) begin
      rdval[k] = shad_q[k-NUM_RW];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      rdval[k] = '0;
    end
    for (int k = 0; k < NUM_RW; k++) begin
      rdval[k] = ctrl_q[k];
    end
    for (int k = NUM_RW; k < NUM_CH; k++) begin
      rdval[k] = stat_data[16*(k-NUM_RW) +: 16];
    end
  end
`endif

  // Next-state logic
  always_comb begin
    addr_d   = addr_q;
    vld_d    = vld_q;
    rd_act_d = rd_act_q;
    dout_d   = dout_q;
    ctrl_d   = ctrl_q;
    wr_stb_d = '0;
    rd_stb_d = '0;
    bad_d    = 1'b0;

    // NE rising ends the access; strobes need a fresh address phase
    if (ne_rise) begin
      vld_d = 1'b0;
    end

    if (latch) begin
      addr_d = db_s[ADDR_W-1:0];
      vld_d  = 1'b1;
    end

    if (nwe_rise && !ne_s && vld_q) begin
      if (addr_rw) begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (addr_q == ADDR_W'(k)) begin
            ctrl_d[k]   = db_s;
            wr_stb_d[k] = 1'b1;
          end
        end
      end else if (!addr_ok) begin
        bad_d = 1'b1;
      end
    end

    // A read only starts with NWE high; NOE low during a write is ignored
    if (noe_fall && !ne_s && nwe_s && vld_q) begin
      rd_act_d = 1'b1;
      dout_d   = 16'h0000;
      if (addr_ok) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr_q == ADDR_W'(k)) begin
            rd_stb_d[k] = 1'b1;
            dout_d      = rdval[k];
          end
        end
      end else begin
        bad_d = 1'b1;
      end
    end

    if (ne_s || noe_s || !nwe_s) begin
      rd_act_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      nadv_p_q <= 1'b1;
      ne_p_q   <= 1'b1;
      nwe_p_q  <= 1'b1;
      noe_p_q  <= 1'b1;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      rd_act_q <= 1'b0;
      dout_q   <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        ctrl_q[k] <= RST_VAL;
      end
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      nadv_p_q <= nadv_s;
      ne_p_q   <= ne_s;
      nwe_p_q  <= nwe_s;
      noe_p_q  <= noe_s;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      rd_act_q <= rd_act_d;
      dout_q   <= dout_d;
      ctrl_q   <= ctrl_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      bad_q    <= bad_d;
    end
  end

  // Drive enable is a flop with async reset, so reset releases DB at once
  assign FPGA_DB = rd_act_q ? dout_q : 16'hzzzz;

  for (genvar k = 0; k < NUM_RW; k++) begin : g_ctrl
    assign ctrl_data[16*k +: 16] = ctrl_q[k];
  end

  assign wr_stb   = wr_stb_q;
  assign rd_stb   = rd_stb_q;
  assign bad_addr = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_fmc_regbank.sv
// tb_fmc_regbank: directed table-driven bench for fmc_regbank.
// Default parameters: 16 channels, 8 control, 2 sync stages.

module tb_fmc_regbank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         nadv = 1'b1;
  logic         ne = 1'b1;
  logic         nwe = 1'b1;
  logic         noe = 1'b1;
  logic [15:0]  drv = 16'h0000;
  logic         tb_oe = 1'b0;
  wire  [15:0]  db;
  logic [127:0] ctrl;
  logic [127:0] stat;
  logic [7:0]   wr_stb;
  logic [15:0]  rd_stb;
  logic         bad;

  assign db = tb_oe ? drv : 16'hzzzz;

  // Released bus reads as FFFF
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (db[i]);
  end

  always #5 clk = ~clk;

  fmc_regbank dut (
    .CLK          (clk),
    .RST          (rst_n),
    .FPGA_NL_NADV (nadv),
    .FPGA_CS_NEL  (ne),
    .FPGA_WR_NWE  (nwe),
    .FPGA_RD_NOE  (noe),
    .FPGA_DB      (db),
    .ctrl_data    (ctrl),
    .stat_data    (stat),
    .wr_stb       (wr_stb),
    .rd_stb       (rd_stb),
    .bad_addr     (bad)
  );

  int checks = 0;
  int failures = 0;

  int wr_tot = 0;
  int rd_tot = 0;
  int bad_tot = 0;
  int wr_last = -1;
  int rd_last = -1;

  always @(negedge clk) begin
    wr_tot  <= wr_tot + $countones(wr_stb);
    rd_tot  <= rd_tot + $countones(rd_stb);
    bad_tot <= bad_tot + 32'(bad);
    for (int i = 0; i < 8; i++) if (wr_stb[i]) wr_last <= i;
    for (int i = 0; i < 16; i++) if (rd_stb[i]) rd_last <= i;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    ne = 1'b0;
    nadv = 1'b0;
    drv = {8'hC3, a};
    tb_oe = 1'b1;
    cyc(5);
    nadv = 1'b1;
    cyc(2);
  endtask

  task automatic write_phase(input logic [15:0] d);
    drv = d;
    nwe = 1'b0;
    cyc(3);
    nwe = 1'b1;
    cyc(4);
    tb_oe = 1'b0;
  endtask

  task automatic read_phase(output logic [15:0] q);
    tb_oe = 1'b0;
    cyc(3);
    noe = 1'b0;
    cyc(6);
    q = db;
    noe = 1'b1;
    cyc(1);
  endtask

  task automatic end_access();
    ne = 1'b1;
    tb_oe = 1'b0;
    cyc(6);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_q;
    int          exp_wr;
    int          exp_rd;
    bit          exp_bad;
  } vec_t;

  vec_t v[16];
  logic [127:0] ctrl_m = '0;

  initial begin
    logic [15:0] q;
    int w0, r0, b0;

    v[0]  = '{1'b1, 8'd8,   16'hFFFF, 16'h0000, -1, -1, 1'b0};
    v[1]  = '{1'b0, 8'd10,  16'h0000, 16'hA5A5, -1, 10, 1'b0};
    v[2]  = '{1'b0, 8'd20,  16'h0000, 16'h0000, -1, -1, 1'b1};
    v[3]  = '{1'b1, 8'd20,  16'h1111, 16'h0000, -1, -1, 1'b1};
    v[4]  = '{1'b1, 8'd0,   16'hBEEF, 16'h0000,  0, -1, 1'b0};
    v[5]  = '{1'b1, 8'd7,   16'h7777, 16'h0000,  7, -1, 1'b0};
    v[6]  = '{1'b0, 8'd0,   16'h0000, 16'hBEEF, -1,  0, 1'b0};
    v[7]  = '{1'b0, 8'd7,   16'h0000, 16'h7777, -1,  7, 1'b0};
    v[8]  = '{1'b0, 8'd3,   16'h0000, 16'h1234, -1,  3, 1'b0};
    v[9]  = '{1'b0, 8'd15,  16'h0000, 16'h5A0F, -1, 15, 1'b0};
    v[10] = '{1'b0, 8'd8,   16'h0000, 16'h5A08, -1,  8, 1'b0};
    v[11] = '{1'b1, 8'd255, 16'h0000, 16'h0000, -1, -1, 1'b1};
    v[12] = '{1'b0, 8'd16,  16'h0000, 16'h0000, -1, -1, 1'b1};
    v[13] = '{1'b0, 8'd1,   16'h0000, 16'h0000, -1,  1, 1'b0};
    v[14] = '{1'b1, 8'd3,   16'hABCD, 16'h0000,  3, -1, 1'b0};
    v[15] = '{1'b0, 8'd3,   16'h0000, 16'hABCD, -1,  3, 1'b0};

    for (int k = 8; k < 16; k++) stat[16*(k-8) +: 16] = 16'h5A00 | 16'(k);
    stat[16*2 +: 16] = 16'hA5A5;

    // Reset state
    cyc(3);
    chk("rst_ctrl", ctrl, 128'h0);
    chk("rst_wr", 128'(wr_stb), 128'h0);
    chk("rst_rd", 128'(rd_stb), 128'h0);
    chk("rst_bad", 128'(bad), 128'h0);
    chk("rst_db", 128'(db), 128'hFFFF);
    rst_n = 1'b1;
    cyc(2);

    // Write 1234 to addr 3 with latency check
    addr_phase(8'd3);
    drv = 16'h1234;
    nwe = 1'b0;
    cyc(3);
    nwe = 1'b1;
    cyc(2);
    chk("wr_early", 128'(wr_stb), 128'h0);
    cyc(1);
    chk("wr_pulse", 128'(wr_stb), 128'h08);
    chk("wr_ctrl3", 128'(ctrl[63:48]), 128'h1234);
    cyc(1);
    chk("wr_pulse_end", 128'(wr_stb), 128'h0);
    cyc(2);
    end_access();
    ctrl_m[63:48] = 16'h1234;
    chk("wr_ctrl_all", ctrl, ctrl_m);

    // Read addr 10 with latency and release check
    w0 = rd_tot;
    addr_phase(8'd10);
    tb_oe = 1'b0;
    cyc(3);
    noe = 1'b0;
    cyc(2);
    chk("rd_early", 128'(db), 128'hFFFF);
    cyc(1);
    chk("rd_data10", 128'(db), 128'hA5A5);
    chk("rd_pulse", 128'(rd_stb), 128'h0400);
    cyc(1);
    chk("rd_pulse_end", 128'(rd_stb), 128'h0);
    cyc(3);
    noe = 1'b1;
    cyc(2);
    chk("rd_hold", 128'(db), 128'hA5A5);
    cyc(1);
    chk("rd_release", 128'(db), 128'hFFFF);
    end_access();
    chk("rd_once", 128'(rd_tot - w0), 128'd1);

    // Table-driven accesses
    for (int i = 0; i < 16; i++) begin
      w0 = wr_tot;
      r0 = rd_tot;
      b0 = bad_tot;
      q = 16'h0000;
      addr_phase(v[i].a);
      if (v[i].wr) write_phase(v[i].d);
      else read_phase(q);
      end_access();
      if (v[i].wr && v[i].a < 8) ctrl_m[16*v[i].a +: 16] = v[i].d;
      if (!v[i].wr) chk($sformatf("v%0d_rdata", i), 128'(q), 128'(v[i].exp_q));
      chk($sformatf("v%0d_wrcnt", i), 128'(wr_tot - w0),
          128'(v[i].exp_wr >= 0));
      if (v[i].exp_wr >= 0)
        chk($sformatf("v%0d_wridx", i), 128'(wr_last), 128'(v[i].exp_wr));
      chk($sformatf("v%0d_rdcnt", i), 128'(rd_tot - r0),
          128'(v[i].exp_rd >= 0));
      if (v[i].exp_rd >= 0)
        chk($sformatf("v%0d_rdidx", i), 128'(rd_last), 128'(v[i].exp_rd));
      chk($sformatf("v%0d_bad", i), 128'(bad_tot - b0), 128'(v[i].exp_bad));
      chk($sformatf("v%0d_ctrl", i), ctrl, ctrl_m);
      chk($sformatf("v%0d_dbz", i), 128'(db), 128'hFFFF);
    end

    // Status change between address latch and read
    stat[16*1 +: 16] = 16'h0001;
    cyc(2);
    addr_phase(8'd9);
    stat[16*1 +: 16] = 16'h0002;
    read_phase(q);
    end_access();
`ifdef FMC_SNAPSHOT_EN
    chk("snap_rd9", 128'(q), 128'h0001);
`else
    chk("live_rd9", 128'(q), 128'h0002);
`endif
    stat[16*1 +: 16] = 16'h5A09;

    // NE abort: a write without a new address phase is dropped
    w0 = wr_tot;
    addr_phase(8'd2);
    ne = 1'b1;
    tb_oe = 1'b0;
    cyc(4);
    ne = 1'b0;
    tb_oe = 1'b1;
    write_phase(16'h9999);
    end_access();
    chk("abort_wrcnt", 128'(wr_tot - w0), 128'd0);
    chk("abort_ctrl", ctrl, ctrl_m);

    // Reset in the middle of a read
    addr_phase(8'd3);
    tb_oe = 1'b0;
    cyc(3);
    noe = 1'b0;
    cyc(5);
    chk("mid_rd_db", 128'(db), 128'hABCD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_db", 128'(db), 128'hFFFF);
    chk("mid_rst_ctrl", ctrl, 128'h0);
    noe = 1'b1;
    ne = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_db", 128'(db), 128'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
